// File: rtl/water_level_pkg.sv
// rtl/water_level_pkg.sv - level codes, probe patterns and FSM states for the tank probe encoder
package water_level_pkg;

  localparam logic [1:0] LVL_CRITICAL = 2'b00;
  localparam logic [1:0] LVL_LOW      = 2'b01;
  localparam logic [1:0] LVL_MID      = 2'b10;
  localparam logic [1:0] LVL_HIGH     = 2'b11;

  localparam logic [2:0] PAT_CRITICAL = 3'b000;
  localparam logic [2:0] PAT_LOW      = 3'b001;
  localparam logic [2:0] PAT_MID      = 3'b011;
  localparam logic [2:0] PAT_HIGH     = 3'b111;

  typedef enum logic [1:0] {ST_INIT, ST_TRACK, ST_FAULT} state_t;

  // Water wets probes bottom-up, so only thermometer-coded patterns are physical.
  function automatic logic pat_plausible(input logic [2:0] p);
    return (p == PAT_CRITICAL) || (p == PAT_LOW) || (p == PAT_MID) || (p == PAT_HIGH);
  endfunction

  function automatic logic [1:0] pat_code(input logic [2:0] p);
    case (p)
      PAT_LOW:  return LVL_LOW;
      PAT_MID:  return LVL_MID;
      PAT_HIGH: return LVL_HIGH;
      default:  return LVL_CRITICAL;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running divider emitting a one-cycle tick every CLK_DIV clocks
module tick_prescaler #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    tick  = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/water_level_sensor_encoder.sv
// rtl/water_level_sensor_encoder.sv - synchronises, debounces and validates three tank probes into a level code
module water_level_sensor_encoder
  import water_level_pkg::*;
#(
  parameter int CLK_DIV  = 50000,
  parameter int DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] probes,
  output logic [1:0] level,
  output logic       level_valid,
  output logic       sensor_fault,
  output logic       level_changed
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] STABLE_LAST = DW'(DEBOUNCE - 1);

  logic          tick;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    cand_q, cand_d;
  logic [DW-1:0] stable_q, stable_d;
  logic          qualify;
  state_t        state_q, state_d;
  logic [1:0]    level_q, level_d;
  logic          valid_q, valid_d;
  logic          fault_q, fault_d;
  logic          changed_q, changed_d;

  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Stable count saturates at STABLE_LAST so a held pattern qualifies only once.
  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    qualify  = 1'b0;
    if (tick) begin
      if (sync2_q != cand_q) begin
        cand_d   = sync2_q;
        stable_d = '0;
        qualify  = (DEBOUNCE == 1);
      end else if (stable_q != STABLE_LAST) begin
        stable_d = stable_q + DW'(1);
        qualify  = (stable_d == STABLE_LAST);
      end
    end
  end

  // On qualify the synchronised pattern equals the candidate, whichever branch fired.
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    valid_d   = valid_q;
    fault_d   = fault_q;
    changed_d = 1'b0;
    if (qualify) begin
      if (pat_plausible(sync2_q)) begin
        state_d   = ST_TRACK;
        level_d   = pat_code(sync2_q);
        valid_d   = 1'b1;
        fault_d   = 1'b0;
        changed_d = (state_q != ST_TRACK) || (pat_code(sync2_q) != level_q);
      end else begin
        state_d   = ST_FAULT;
        valid_d   = 1'b0;
        fault_d   = 1'b1;
        changed_d = (state_q == ST_TRACK);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 3'b000;
      sync2_q   <= 3'b000;
      cand_q    <= 3'b000;
      stable_q  <= '0;
      state_q   <= ST_INIT;
      level_q   <= LVL_CRITICAL;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= probes;
      sync2_q   <= sync1_q;
      cand_q    <= cand_d;
      stable_q  <= stable_d;
      state_q   <= state_d;
      level_q   <= level_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      changed_q <= changed_d;
    end
  end

  assign level         = level_q;
  assign level_valid   = valid_q;
  assign sensor_fault  = fault_q;
  assign level_changed = changed_q;

endmodule
